// File: rtl/mips_main_control_pkg.sv
// Shared types for the multicycle MIPS main control unit.
// State encodings, opcode/funct constants and the control word bundle.
package mips_main_control_pkg;

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_RTYPEEX = 4'd7,
    S_RTYPEWB = 4'd8,
    S_BEQEX   = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JEX     = 4'd12,
    S_JREX    = 4'd13,
    S_BNEEX   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM4 = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FN    = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_OUT    = 2'b01;
  localparam logic [1:0] PC_JMP    = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    logic       instrdone;
    logic       illegalop;
  } ctrl_t;

  function automatic state_t decode_next(
    input logic [5:0] op,
    input logic [5:0] funct
  );
    state_t ns;
    ns = S_FETCH;
    unique case (1'b1)
      (op == OP_LW),
      (op == OP_SW):    ns = S_MEMADR;
      (op == OP_RTYPE): ns = (funct == FN_JR) ? S_JREX : S_RTYPEEX;
      (op == OP_BEQ):   ns = S_BEQEX;
      (op == OP_ADDI):  ns = S_ADDIEX;
      (op == OP_J):     ns = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
      (op == OP_BNE):   ns = S_BNEEX;
`endif
      default:          ns = S_FETCH;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/main_ctrl_decode.sv
// Combinational state-to-control-word decode for mips_main_control.
// Only DECODE looks at an input (illegal), to flag unsupported opcodes.
module main_ctrl_decode
  import mips_main_control_pkg::*;
(
  input  state_t state,
  input  logic   illegal,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = SRCB_4;
        ctrl.pcwrite = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb   = SRCB_IMM4;
        ctrl.illegalop = illegal;
        ctrl.instrdone = illegal;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg  = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.memwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALU_FN;
      end
      S_RTYPEWB: begin
        ctrl.regdst    = 1'b1;
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        ctrl.alusrca   = 1'b1;
        ctrl.aluop     = ALU_SUB;
        ctrl.pcsrc     = PC_OUT;
        ctrl.branch    = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_ADDIWB: begin
        ctrl.regwrite  = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_JEX: begin
        ctrl.pcsrc     = PC_JMP;
        ctrl.pcwrite   = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      S_JREX: begin
        ctrl.alusrca   = 1'b1;
        ctrl.aluop     = ALU_FN;
        ctrl.pcsrc     = PC_ALU;
        ctrl.pcwrite   = 1'b1;
        ctrl.instrdone = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM: state register, next state, PCEn.
// Optional bne support is enabled by defining MIPS_CTRL_BNE_EN.
module mips_main_control
  import mips_main_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       IllegalOp
);

  state_t state;
  state_t state_nx;
  state_t dec_nx;
  ctrl_t  ctrl;
  logic   illegal;
  logic   taken;

  assign dec_nx  = decode_next(Op, Funct);
  assign illegal = (dec_nx == S_FETCH);

  always_comb begin
    state_nx = S_FETCH;
    unique case (state)
      S_RESET:   state_nx = S_FETCH;
      S_FETCH:   state_nx = S_DECODE;
      S_DECODE:  state_nx = dec_nx;
      S_MEMADR:  state_nx = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_nx = S_MEMWB;
      S_RTYPEEX: state_nx = S_RTYPEWB;
      S_ADDIEX:  state_nx = S_ADDIWB;
      default:   state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RESET;
    else      state <= state_nx;
  end

  main_ctrl_decode u_dec (
    .state   (state),
    .illegal (illegal),
    .ctrl    (ctrl)
  );

`ifdef MIPS_CTRL_BNE_EN
  assign taken = (state == S_BNEEX) ? ~Zero : Zero;
`else
  assign taken = Zero;
`endif

  assign PCEn      = ctrl.pcwrite | (ctrl.branch & taken);
  assign IorD      = ctrl.iord;
  assign MemWrite  = ctrl.memwrite;
  assign IRWrite   = ctrl.irwrite;
  assign RegDst    = ctrl.regdst;
  assign MemtoReg  = ctrl.memtoreg;
  assign RegWrite  = ctrl.regwrite;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ALUOp     = ctrl.aluop;
  assign PCSrc     = ctrl.pcsrc;
  assign InstrDone = ctrl.instrdone;
  assign IllegalOp = ctrl.illegalop;

endmodule

// File: tb/tb_mips_main_control.sv
// Testbench for mips_main_control: table vectors, reset corners, random mix.
module tb_mips_main_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, InstrDone, IllegalOp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_main_control dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp)
  );

  // Output vector bit positions
  localparam int B_IORD = 15, B_MEMW = 14, B_IRW = 13, B_RDST = 12;
  localparam int B_M2R = 11, B_REGW = 10, B_SRCA = 9, B_SRCB = 7;
  localparam int B_ALUOP = 5, B_PCSRC = 3, B_PCEN = 2, B_DONE = 1;
  localparam int B_ILL = 0;

  localparam int C_LW = 0, C_SW = 1, C_RT = 2, C_JR = 3, C_BEQ = 4;
  localparam int C_BNE = 5, C_ADDI = 6, C_J = 7, C_ILL = 8;

  function automatic logic [15:0] dut_vec();
    return {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
            ALUSrcB, ALUOp, PCSrc, PCEn, InstrDone, IllegalOp};
  endfunction

  function automatic int cls_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return (fn == 6'b001000) ? C_JR : C_RT;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
`ifdef MIPS_CTRL_BNE_EN
      6'b000101: return C_BNE;
`endif
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int lat_of(input int c);
    case (c)
      C_LW:                   return 5;
      C_SW, C_RT, C_ADDI:     return 4;
      C_BEQ, C_BNE, C_J, C_JR: return 3;
      default:                return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = FETCH) of an instruction of class c
  function automatic logic [15:0] exp_vec(input int c, input int k,
                                          input logic z);
    logic [15:0] v;
    v = '0;
    if (k == 0) begin
      v[B_IRW] = 1'b1;
      v[B_SRCB +: 2] = 2'b01;
      v[B_PCEN] = 1'b1;
    end else if (k == 1) begin
      v[B_SRCB +: 2] = 2'b11;
      if (c == C_ILL) begin
        v[B_ILL] = 1'b1;
        v[B_DONE] = 1'b1;
      end
    end else if (k == 2) begin
      case (c)
        C_LW, C_SW, C_ADDI: begin
          v[B_SRCA] = 1'b1;
          v[B_SRCB +: 2] = 2'b10;
        end
        C_RT: begin
          v[B_SRCA] = 1'b1;
          v[B_ALUOP +: 2] = 2'b10;
        end
        C_JR: begin
          v[B_SRCA] = 1'b1;
          v[B_ALUOP +: 2] = 2'b10;
          v[B_PCEN] = 1'b1;
          v[B_DONE] = 1'b1;
        end
        C_BEQ, C_BNE: begin
          v[B_SRCA] = 1'b1;
          v[B_ALUOP +: 2] = 2'b01;
          v[B_PCSRC +: 2] = 2'b01;
          v[B_PCEN] = (c == C_BEQ) ? z : ~z;
          v[B_DONE] = 1'b1;
        end
        C_J: begin
          v[B_PCSRC +: 2] = 2'b10;
          v[B_PCEN] = 1'b1;
          v[B_DONE] = 1'b1;
        end
        default: v = '0;
      endcase
    end else if (k == 3) begin
      case (c)
        C_LW: v[B_IORD] = 1'b1;
        C_SW: begin
          v[B_IORD] = 1'b1;
          v[B_MEMW] = 1'b1;
          v[B_DONE] = 1'b1;
        end
        C_RT: begin
          v[B_RDST] = 1'b1;
          v[B_REGW] = 1'b1;
          v[B_DONE] = 1'b1;
        end
        C_ADDI: begin
          v[B_REGW] = 1'b1;
          v[B_DONE] = 1'b1;
        end
        default: v = '0;
      endcase
    end else if (k == 4 && c == C_LW) begin
      v[B_M2R] = 1'b1;
      v[B_REGW] = 1'b1;
      v[B_DONE] = 1'b1;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic resync();
    rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // zmode: 0/1 = fixed Zero, 2 = random Zero every cycle
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input int zmode,
                           input int ncyc, output logic [15:0] last);
    int c;
    int e0;
    c = cls_of(op, fn);
    e0 = errors;
    last = '0;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #2;
      Op    = (k == 0) ? 6'($urandom) : op;
      Funct = (k == 0) ? 6'($urandom) : fn;
      Zero  = (zmode == 2) ? 1'($urandom) : 1'(zmode);
      #1;
      last = dut_vec();
      chk($sformatf("%s cyc%0d", name, k + 1), last, exp_vec(c, k, Zero));
    end
    if (errors != e0) resync();
  endtask

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    int          z;
    int          lat;
    logic [15:0] last;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] lv;
  logic [5:0] pool[10];

  initial begin
    tbl.push_back('{"lw",      6'b100011, 6'b000000, 0, 5, 16'h0C02});
    tbl.push_back('{"sw",      6'b101011, 6'b000000, 1, 4, 16'hC002});
    tbl.push_back('{"add",     6'b000000, 6'b100000, 0, 4, 16'h1402});
    tbl.push_back('{"sub",     6'b000000, 6'b100010, 1, 4, 16'h1402});
    tbl.push_back('{"addi",    6'b001000, 6'b001000, 0, 4, 16'h0402});
    tbl.push_back('{"beq z1",  6'b000100, 6'b000000, 1, 3, 16'h022E});
    tbl.push_back('{"beq z0",  6'b000100, 6'b000000, 0, 3, 16'h022A});
    tbl.push_back('{"j",       6'b000010, 6'b000000, 1, 3, 16'h0016});
    tbl.push_back('{"jr",      6'b000000, 6'b001000, 0, 3, 16'h0246});
    tbl.push_back('{"ill 3f",  6'b111111, 6'b000000, 0, 2, 16'h0183});
    tbl.push_back('{"ill jal", 6'b000011, 6'b000000, 1, 2, 16'h0183});
`ifdef MIPS_CTRL_BNE_EN
    tbl.push_back('{"bne z0",  6'b000101, 6'b000000, 0, 3, 16'h022E});
    tbl.push_back('{"bne z1",  6'b000101, 6'b000000, 1, 3, 16'h022A});
`else
    tbl.push_back('{"op05 ill", 6'b000101, 6'b000000, 0, 2, 16'h0183});
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #3 chk("reset outputs", dut_vec(), 16'h0000);
    #2 rst = 1'b1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].fn, tbl[i].z,
                tbl[i].lat, lv);
      chk({tbl[i].name, " last"}, lv, tbl[i].last);
    end

    // Reset during MEMWR must kill the write at once
    run_instr("sw pre", 6'b101011, 6'b0, 2, 3, lv);
    @(posedge clk);
    #3 chk1("memwr before rst", MemWrite, 1'b1);
    #1 rst = 1'b0;
    #1 chk1("memwr after rst", MemWrite, 1'b0);
    chk("rst mid memwr", dut_vec(), 16'h0000);
    @(posedge clk);
    #3 chk("held in reset", dut_vec(), 16'h0000);
    #2 rst = 1'b1;
    run_instr("after rst", 6'b100011, 6'b0, 2, 5, lv);

    // Reset during MEMWB must kill the register write
    run_instr("lw pre", 6'b100011, 6'b0, 2, 4, lv);
    @(posedge clk);
    #3 chk1("regw before rst", RegWrite, 1'b1);
    #1 rst = 1'b0;
    #1 chk1("regw after rst", RegWrite, 1'b0);
    #3 rst = 1'b1;
    run_instr("after rst2", 6'b000000, 6'b100101, 2, 4, lv);

    // Random instruction mix
    pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
             6'b001000, 6'b000010, 6'b000101, 6'b111111, 6'b000000};
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      int c;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom)
                                       : pool[$urandom_range(0, 9)];
      fn = ($urandom_range(0, 2) == 0) ? 6'b001000 : 6'($urandom);
      c = cls_of(op, fn);
      run_instr($sformatf("rnd%0d op%b", n, op), op, fn, 2, lat_of(c), lv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
